ibex_mem_arbiter: RTL and testbench

IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

---
 rtl/ibex_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_ibex_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - two-port (fetch/load-store) arbiter onto one in-order memory bus
// Define IBEX_MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority, data over instr.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,

  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    SelInstr = 1'b0,
    SelData  = 1'b1
  } sel_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  state_e              state_q, state_d;
  sel_e                sel_q, sel_d;
  sel_e                policy_sel;
  sel_e                sel;
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [MaxOutstanding-1:0] order_q;
  logic                full;
  logic                empty;
  logic                grant;
  logic                pop;
  logic                head_is_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

`ifdef IBEX_MEM_ARB_RR_EN
  sel_e last_q;

  // On contention the port that did not win last time goes first.
  always_comb begin
    policy_sel = SelInstr;
    if (instr_req_i && data_req_i) begin
      policy_sel = (last_q == SelData) ? SelInstr : SelData;
    end else if (data_req_i) begin
      policy_sel = SelData;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= SelInstr;
    end else if (grant) begin
      last_q <= sel;
    end
  end
`else
  always_comb begin
    policy_sel = data_req_i ? SelData : SelInstr;
  end
`endif

  // A request presented but not accepted keeps its owner until granted.
  assign sel   = (state_q == StLocked) ? sel_q : policy_sel;
  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);

  assign mem_req_o   = (instr_req_i | data_req_i) & ~full & ~rst_i;
  assign grant       = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = grant & (sel == SelInstr);
  assign data_gnt_o  = grant & (sel == SelData);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = 32'h0;
    if (sel == SelData) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = StLocked;
          sel_d   = sel;
        end
      end
      StLocked: begin
        if (grant) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= SelInstr;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Responses with nothing outstanding are stray and are dropped.
  assign pop            = mem_rvalid_i & ~empty & ~rst_i;
  assign head_is_data   = order_q[rptr_q];
  assign instr_rvalid_o = pop & ~head_is_data;
  assign data_rvalid_o  = pop & head_is_data;
  assign rsp_rdata_o    = mem_rdata_i;
  assign rsp_err_o      = mem_err_i & (instr_rvalid_o | data_rvalid_o);

  always_comb begin
    count_d = count_q;
    case ({grant, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (grant) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) begin
      order_q[wptr_q] <= (sel == SelData);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(instr_gnt_o && data_gnt_o))
        else $error("instr and data granted in the same cycle");
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - directed self-checking bench for ibex_mem_arbiter
module tb_ibex_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int n_checks = 0;
  int n_pass   = 0;

  ibex_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    mem_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    next_cycle();
    rst_i = 1'b0;
  endtask

  logic exp_data;

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) next_cycle();

    // Reset holds every output quiet even with all inputs active.
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    check("rst_mem_req",      mem_req_o,      1'b0);
    check("rst_instr_gnt",    instr_gnt_o,    1'b0);
    check("rst_data_gnt",     data_gnt_o,     1'b0);
    check("rst_instr_rvalid", instr_rvalid_o, 1'b0);
    check("rst_data_rvalid",  data_rvalid_o,  1'b0);
    next_cycle();

    // Both requesting, bus always ready; a response each cycle keeps count at 1.
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
`ifdef IBEX_MEM_ARB_RR_EN
      exp_data = ((i % 2) == 0);
`else
      exp_data = 1'b1;
`endif
      check($sformatf("both_data_gnt_%0d", i),  data_gnt_o,  exp_data);
      check($sformatf("both_instr_gnt_%0d", i), instr_gnt_o, !exp_data);
      if (i == 0) check("stray_rvalid_dropped", instr_rvalid_o | data_rvalid_o, 1'b0);
      if (i == 1) check("first_rsp_to_data", data_rvalid_o, 1'b1);
      next_cycle();
    end

    // Instr stalled three cycles; data arriving mid-stall must not steal the bus.
    do_reset();
    instr_addr_i = 32'h0000_1000;
    data_addr_i  = 32'h0000_2000;
    data_wdata_i = 32'h0000_5555;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    instr_req_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) data_req_i = 1'b1;
      @(negedge clk_i);
      check($sformatf("lock_addr_%0d", i),  mem_addr_o, 32'h0000_1000);
      check($sformatf("lock_req_%0d", i),   mem_req_o,  1'b1);
      check($sformatf("lock_nogntd_%0d", i), data_gnt_o, 1'b0);
      if (i == 2) begin
        check("fetch_we",    mem_we_o,    1'b0);
        check("fetch_be",    mem_be_o,    4'hF);
        check("fetch_wdata", mem_wdata_o, 32'h0);
      end
      next_cycle();
    end
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("lock_instr_gnt", instr_gnt_o, 1'b1);
    check("lock_data_gnt",  data_gnt_o,  1'b0);
    check("lock_gnt_addr",  mem_addr_o,  32'h0000_1000);
    next_cycle();
    instr_req_i = 1'b0;
    @(negedge clk_i);
    check("data_gnt_after", data_gnt_o,  1'b1);
    check("data_addr",      mem_addr_o,  32'h0000_2000);
    check("data_we",        mem_we_o,    1'b1);
    check("data_be",        mem_be_o,    4'h3);
    check("data_wdata",     mem_wdata_o, 32'h0000_5555);
    next_cycle();

    // Two outstanding: blocked, still blocked in the pop cycle, issues the next cycle.
    @(negedge clk_i);
    check("full_block", mem_req_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    check("full_pop_no_req",  mem_req_o,      1'b0);
    check("full_pop_instr_rv", instr_rvalid_o, 1'b1);
    next_cycle();
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("after_pop_req", mem_req_o,  1'b1);
    check("after_pop_gnt", data_gnt_o, 1'b1);
    next_cycle();

    // Responses return in issue order to the right port.
    do_reset();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_00A0;
    mem_gnt_i    = 1'b1;
    @(negedge clk_i);
    check("order_a_gnt", instr_gnt_o, 1'b1);
    next_cycle();
    instr_req_i = 1'b0;
    data_req_i  = 1'b1;
    data_addr_i = 32'h0000_00B0;
    @(negedge clk_i);
    check("order_b_gnt", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    @(negedge clk_i);
    check("order_rsp1_instr", instr_rvalid_o, 1'b1);
    check("order_rsp1_data",  data_rvalid_o,  1'b0);
    check("order_rsp1_rdata", rsp_rdata_o,    32'h1111_1111);
    next_cycle();
    mem_rdata_i = 32'h2222_2222;
    @(negedge clk_i);
    check("order_rsp2_data",  data_rvalid_o,  1'b1);
    check("order_rsp2_instr", instr_rvalid_o, 1'b0);
    check("order_rsp2_rdata", rsp_rdata_o,    32'h2222_2222);
    next_cycle();

    // Stray response on empty, then reset with one outstanding discards it.
    do_reset();
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    @(negedge clk_i);
    check("empty_rvalid", instr_rvalid_o | data_rvalid_o, 1'b0);
    check("empty_err",    rsp_err_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    instr_req_i  = 1'b1;
    mem_gnt_i    = 1'b1;
    @(negedge clk_i);
    check("pre_rst_gnt", instr_gnt_o, 1'b1);
    next_cycle();
    do_reset();
    mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_rvalid", instr_rvalid_o | data_rvalid_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 1'b0;
    instr_req_i  = 1'b1;
    mem_gnt_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("post_rst_req_%0d", i), mem_req_o, (i < 2));
      next_cycle();
    end

    // Error response on a load.
    do_reset();
    data_req_i  = 1'b1;
    data_addr_i = 32'h0000_3000;
    mem_gnt_i   = 1'b1;
    @(negedge clk_i);
    check("err_gnt", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    @(negedge clk_i);
    check("err_data_rvalid",  data_rvalid_o,  1'b1);
    check("err_rsp_err",      rsp_err_o,      1'b1);
    check("err_instr_rvalid", instr_rvalid_o, 1'b0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
